// File: rtl/ws2812b_multi.sv
// ----------------------------------------------------------------------------
// ws2812b_multi
//
// Drives CHANNELS WS2812B LED strings in lockstep. Each frame sends LEDS
// pixels of BPP bits (MSB first) to every string, then holds all lines low
// for the latch period. Pixels come from a frame source over a valid/ready
// stream, one CHANNELS*BPP word per pixel, through a one-pixel holding
// buffer so the next pixel can be fetched while the current one shifts out.
//
// Parameters:
//   CHANNELS  number of parallel strings (1..16)
//   LEDS      pixels per string (>=1)
//   BPP       bits per pixel (>=2), sent MSB first
//   T0H/T1H   high time of a 0 / 1 bit, in clocks (T0H < T1H < TBIT)
//   TBIT      bit period in clocks
//   TRST      latch low time in clocks
//   CW        timing counter width, 2^CW > TRST and 2^CW >= TBIT
//
// Ports:
//   CLK50       system clock
//   RESET_N     asynchronous active-low reset
//   START       one-cycle frame request, honoured only in IDLE
//   CONTINUOUS  restart automatically at the end of each latch
//   PIX_DATA    pixel for all strings, channel c at [c*BPP +: BPP]
//   PIX_VALID   PIX_DATA is valid
//   PIX_READY   driver accepts a pixel this cycle
//   PIX_INDEX   index of the next pixel to be accepted
//   WS          registered serial data line per string
//   BUSY        high in every state except IDLE
//   FRAME_DONE  one-cycle pulse on the final latch clock
//   UNDERRUN    sticky source-starvation flag, cleared at frame start
//   STATE       FSM state: IDLE=0, FETCH=1, SHIFT=2, LATCH=3
//
// Pixel stream handshake: a pixel is transferred on every rising clock edge
// where PIX_VALID and PIX_READY are both high. PIX_VALID may rise or fall at
// any time; PIX_READY depends only on registered state (never on PIX_VALID),
// and once the frame has accepted LEDS pixels it stays low until the next
// frame starts.
// ----------------------------------------------------------------------------
module ws2812b_multi #(
  parameter int CHANNELS = 4,
  parameter int LEDS     = 256,
  parameter int BPP      = 24,
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int TBIT     = 63,
  parameter int TRST     = 2500,
  parameter int CW       = 12
) (
  input  logic                                     CLK50,
  input  logic                                     RESET_N,
  input  logic                                     START,
  input  logic                                     CONTINUOUS,
  input  logic [CHANNELS*BPP-1:0]                  PIX_DATA,
  input  logic                                     PIX_VALID,
  output logic                                     PIX_READY,
  output logic [((LEDS > 1) ? $clog2(LEDS) : 1)-1:0] PIX_INDEX,
  output logic [CHANNELS-1:0]                      WS,
  output logic                                     BUSY,
  output logic                                     FRAME_DONE,
  output logic                                     UNDERRUN,
  output logic [1:0]                               STATE
);

  localparam int IW = (LEDS > 1) ? $clog2(LEDS) : 1;   // PIX_INDEX width
  localparam int AW = $clog2(LEDS + 1);                // accepted-pixel count
  localparam int BW = (BPP > 1) ? $clog2(BPP) : 1;     // bit index width
  localparam int DW = CHANNELS * BPP;

  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [CW-1:0] TBIT_M1  = CW'(TBIT - 1);
  localparam logic [CW-1:0] TRST_C   = CW'(TRST);
  localparam logic [BW-1:0] BIT_TOP  = BW'(BPP - 1);
  localparam logic [AW-1:0] LEDS_C   = AW'(LEDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t              r_state;
  logic [DW-1:0]       r_shift;      // pixel being sent, MSB of each channel first
  logic [DW-1:0]       r_buf;        // holding buffer for the next pixel
  logic                r_buf_full;
  logic [BW-1:0]       r_bit;        // bits remaining in current pixel, minus one
  logic [CW-1:0]       r_cnt;        // bit-period counter in SHIFT, latch counter in LATCH
  logic [AW-1:0]       r_acc;        // pixels accepted this frame
  logic [CHANNELS-1:0] r_ws;
  logic                r_frame_done;
  logic                r_underrun;

  logic                w_ready;
  logic                w_xfer;
  logic                w_last_clk;   // final clock of a bit period
  logic [CHANNELS-1:0] w_ws_next;
  logic [DW-1:0]       w_shl;        // every channel shifted left by one bit

  assign w_ready    = ((r_state == S_FETCH) || ((r_state == S_SHIFT) && !r_buf_full)) &&
                      (r_acc != LEDS_C);
  assign w_xfer     = w_ready && PIX_VALID;
  assign w_last_clk = (r_cnt == TBIT_M1);

  // Line level for the current clock of the bit period; registered into r_ws,
  // so the line follows r_cnt by one clock.
  always_comb begin
    w_ws_next = '0;
    w_shl     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_ws_next[c] = r_shift[c*BPP + BPP - 1] ? (r_cnt < T1H_C) : (r_cnt < T0H_C);
      w_shl[c*BPP +: BPP] = {r_shift[c*BPP +: BPP-1], 1'b0};
    end
  end

  always_ff @(posedge CLK50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_bit        <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_ws         <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_ws         <= '0;

      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state    <= S_FETCH;
            r_acc      <= '0;
            r_buf_full <= 1'b0;
            r_underrun <= 1'b0;
          end
        end

        S_FETCH: begin
          if (w_xfer) begin
            r_shift <= PIX_DATA;
            r_bit   <= BIT_TOP;
            r_cnt   <= '0;
            r_acc   <= r_acc + 1'b1;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_ws <= w_ws_next;

          // Transfers in SHIFT normally land in the holding buffer.
          if (w_xfer) begin
            r_buf      <= PIX_DATA;
            r_buf_full <= 1'b1;
            r_acc      <= r_acc + 1'b1;
          end

          if (w_last_clk) begin
            r_cnt <= '0;
            if (r_bit != '0) begin
              r_bit   <= r_bit - 1'b1;
              r_shift <= w_shl;
            end else if (r_buf_full) begin
              r_shift    <= r_buf;
              r_buf_full <= 1'b0;
              r_bit      <= BIT_TOP;
            end else if (w_xfer) begin
              // Pixel arrives on the very last clock with the buffer empty:
              // send it straight on instead of parking it in the buffer.
              r_shift    <= PIX_DATA;
              r_buf_full <= 1'b0;
              r_bit      <= BIT_TOP;
            end else begin
              // Nothing left to send: either the frame is complete or the
              // source starved and the frame is cut short.
              if (r_acc != LEDS_C) begin
                r_underrun <= 1'b1;
              end
              r_state <= S_LATCH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_LATCH: begin
          // The line is already low on entry (WS lags the state by a clock).
          // After TRST latch clocks FRAME_DONE is raised for the final latch
          // clock, and the state is left on the clock after that.
          if (r_frame_done) begin
            if (CONTINUOUS) begin
              r_state    <= S_FETCH;
              r_acc      <= '0;
              r_buf_full <= 1'b0;
              r_underrun <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_cnt == TRST_C) begin
            r_frame_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PIX_READY  = w_ready;
  assign PIX_INDEX  = r_acc[IW-1:0];
  assign WS         = r_ws;
  assign BUSY       = (r_state != S_IDLE);
  assign FRAME_DONE = r_frame_done;
  assign UNDERRUN   = r_underrun;
  assign STATE      = r_state;

endmodule

// File: tb/tb_ws2812b_multi.sv
// ----------------------------------------------------------------------------
// tb_ws2812b_multi
//
// Directed bench for ws2812b_multi with CHANNELS=2, LEDS=3, BPP=24 and the
// default timing. Inputs change 1 time unit after a rising edge; outputs are
// sampled on falling edges. Expected values are worked out by hand from the
// timing parameters (T0H=20, T1H=40, TBIT=63, TRST=2500).
// ----------------------------------------------------------------------------
module tb_ws2812b_multi;

  localparam int CH   = 2;
  localparam int NL   = 3;
  localparam int NB   = 24;
  localparam int TBIT = 63;
  localparam int TRST = 2500;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              continuous;
  logic [CH*NB-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [1:0]        pix_index;
  logic [CH-1:0]     ws;
  logic              busy;
  logic              frame_done;
  logic              underrun;
  logic [1:0]        state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [1:0] exp_q[$];
  logic [1:0] xfer_q[$];

  ws2812b_multi #(
    .CHANNELS(CH),
    .LEDS(NL),
    .BPP(NB)
  ) dut (
    .CLK50(clk),
    .RESET_N(rst_n),
    .START(start),
    .CONTINUOUS(continuous),
    .PIX_DATA(pix_data),
    .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready),
    .PIX_INDEX(pix_index),
    .WS(ws),
    .BUSY(busy),
    .FRAME_DONE(frame_done),
    .UNDERRUN(underrun),
    .STATE(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the index of every transfer; sampled mid-cycle, the values are
  // those the next rising edge will see.
  always @(negedge clk) begin
    if (pix_valid && pix_ready) xfer_q.push_back(pix_index);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_xfers(input string tag);
    check({tag, "_count"}, xfer_q.size(), exp_q.size());
    while (exp_q.size() > 0 && xfer_q.size() > 0) begin
      check({tag, "_index"}, 32'(xfer_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    xfer_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start(output int t0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_rise(input string tag, output int t);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (ws[0]) found = 1'b1;
    end
    check({tag, "_seen"}, 32'(found), 1);
    t = cyc;
  endtask

  task automatic wait_fd(input string tag, output int t);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 10000 && !found; k++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    check({tag, "_seen"}, 32'(found), 1);
    t = cyc;
  endtask

  // Called on the sample where both lines just rose; returns on the sample
  // where they rise again. Values are sample offsets from the start rise.
  task automatic measure_bit(output int h0, output int h1, output int p0, output int p1);
    h0 = -1; h1 = -1; p0 = -1; p1 = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (h0 < 0 && !ws[0]) h0 = i;
      if (h1 < 0 && !ws[1]) h1 = i;
      if (p0 < 0 && h0 >= 0 && ws[0]) p0 = i;
      if (p1 < 0 && h1 >= 0 && ws[1]) p1 = i;
      if (p0 >= 0 && p1 >= 0) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t_rise, t_fd, t_rise2;
    int h0, h1, p0, p1;
    int fd_seen, state_busy;

    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = {24'h00FF00, 24'hFF0000};   // ch1, ch0

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ws",    32'(ws), 0);
    check("rst_state", 32'(state), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ready", 32'(pix_ready), 0);
    check("rst_index", 32'(pix_index), 0);
    check("rst_fd",    32'(frame_done), 0);
    check("rst_unf",   32'(underrun), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ws",    32'(ws), 0);
    check("idle_busy",  32'(busy), 0);
    check("idle_state", 32'(state), 0);

    // ---- Full frame, always-valid source ----
    @(posedge clk); #1 pix_valid = 1'b1;
    xfer_q.delete();
    pulse_start(t0);
    @(negedge clk);
    check("fetch_state", 32'(state), 1);
    check("fetch_busy",  32'(busy), 1);
    check("fetch_ready", 32'(pix_ready), 1);
    check("fetch_index", 32'(pix_index), 0);
    wait_rise("f1_rise", t_rise);
    check("f1_rise_latency", t_rise - t0, 2);
    check("f1_rise_ws",      32'(ws), 3);
    check("f1_shift_state",  32'(state), 2);
    check("f1_buf_index",    32'(pix_index), 2);
    check("f1_buf_ready",    32'(pix_ready), 0);

    // ch0 = FF0000: first 8 bits are ones; ch1 = 00FF00: middle 8 bits are ones.
    for (int b = 0; b < NB; b++) begin
      measure_bit(h0, h1, p0, p1);
      check($sformatf("bit%0d_ch0_high", b), h0, (b < 8) ? 40 : 20);
      check($sformatf("bit%0d_ch1_high", b), h1, (b >= 8 && b < 16) ? 40 : 20);
      check($sformatf("bit%0d_ch0_period", b), p0, TBIT);
      check($sformatf("bit%0d_ch1_period", b), p1, TBIT);
    end

    wait_fd("f1_fd", t_fd);
    check("f1_frame_len", t_fd - t_rise, NL*NB*TBIT + TRST);   // 7036
    check("f1_fd_state",  32'(state), 3);
    check("f1_fd_ws",     32'(ws), 0);
    check("f1_fd_unf",    32'(underrun), 0);
    check("f1_fd_index",  32'(pix_index), 3);
    @(negedge clk);
    check("f1_end_fd",    32'(frame_done), 0);
    check("f1_end_state", 32'(state), 0);
    check("f1_end_busy",  32'(busy), 0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    check_xfers("f1_xfer");

    // ---- Underrun: pixel 1 is never offered ----
    pulse_start(t0);
    @(posedge clk); #1 pix_valid = 1'b0;   // pixel 0 taken on that edge
    wait_rise("un_rise", t_rise);
    check("un_rise_latency", t_rise - t0, 2);
    repeat (NB*TBIT - 2) @(negedge clk);
    check("un_pre_state", 32'(state), 2);
    @(negedge clk);
    check("un_latch_state", 32'(state), 3);
    check("un_flag",        32'(underrun), 1);
    check("un_ready",       32'(pix_ready), 0);
    @(negedge clk);
    check("un_ws",          32'(ws), 0);
    check("un_index",       32'(pix_index), 1);
    wait_fd("un_fd", t_fd);
    check("un_frame_len",   t_fd - t_rise, NB*TBIT + TRST);    // 4012
    @(negedge clk);
    check("un_end_state",   32'(state), 0);
    check("un_sticky",      32'(underrun), 1);
    exp_q.push_back(2'd0);
    check_xfers("un_xfer");

    // ---- Continuous mode; START during SHIFT is ignored ----
    @(posedge clk); #1 begin pix_valid = 1'b1; continuous = 1'b1; end
    pulse_start(t0);
    @(negedge clk);
    check("c_unf_cleared", 32'(underrun), 0);
    check("c_fetch_state", 32'(state), 1);
    wait_rise("c_rise", t_rise);
    repeat (100) @(negedge clk);
    pulse_start(t0);
    @(negedge clk);
    check("c_ign_state", 32'(state), 2);
    check("c_ign_index", 32'(pix_index), 2);
    repeat (2000) @(negedge clk);
    pulse_start(t0);
    @(negedge clk);
    check("c_ign2_state", 32'(state), 2);
    wait_fd("c_fd", t_fd);
    check("c_frame_len", t_fd - t_rise, NL*NB*TBIT + TRST);
    check("c_fd_state",  32'(state), 3);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    check_xfers("c_xfer");
    @(negedge clk);
    check("c_next_state", 32'(state), 1);
    check("c_next_index", 32'(pix_index), 0);
    check("c_next_busy",  32'(busy), 1);
    check("c_next_fd",    32'(frame_done), 0);
    wait_rise("c_rise2", t_rise2);
    check("c_restart_latency", t_rise2 - t_fd, 3);

    // ---- Asynchronous reset mid-SHIFT while the lines are high ----
    repeat (5) @(negedge clk);
    check("ar_ws_high", 32'(ws), 3);
    #3 rst_n = 1'b0;
    #1;
    check("ar_ws",    32'(ws), 0);
    check("ar_state", 32'(state), 0);
    check("ar_busy",  32'(busy), 0);
    check("ar_ready", 32'(pix_ready), 0);
    check("ar_index", 32'(pix_index), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    fd_seen = 0;
    state_busy = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) fd_seen++;
      if (state != 2'd0) state_busy++;
    end
    check("ar_no_fd",    fd_seen, 0);
    check("ar_stay_idle", state_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ws2812b_multi.md
Name: ws2812b_multi

Overview:
- Parametrised successor to the single-string WS2812B driver.
- Drives CHANNELS LED strings in lockstep, LEDS pixels each, BPP bits per pixel (24 = GRB, 32 = GRBW).
- Pixel data arrives over a valid/ready stream from a frame source, through a one-pixel holding buffer, instead of a fixed internal memory.
- Adds one-shot and continuous refresh, underrun detection, and a frame-done strobe for the frame-buffer controller.

Parameters:
- CHANNELS, 4, number of parallel LED strings (1..16).
- LEDS, 256, pixels per string (>=1).
- BPP, 24, bits per pixel, sent MSB first.
- T0H, 20, high time of a 0 bit, in clocks (0.4 us at 50 MHz).
- T1H, 40, high time of a 1 bit, in clocks.
- TBIT, 63, total bit period in clocks; requires T0H < T1H < TBIT.
- TRST, 2500, latch low time in clocks (50 us).
- CW, 12, timing counter width; requires 2^CW > TRST.

Ports:
- CLK50 input 1: system clock, 50 MHz.
- RESET_N input 1: asynchronous, active-low reset.
- START input 1: one-cycle frame request; honoured only in IDLE.
- CONTINUOUS input 1: when 1, a new frame starts automatically after each latch.
- PIX_DATA input CHANNELS*BPP: pixel for all strings; channel c occupies bits [c*BPP +: BPP].
- PIX_VALID input 1: PIX_DATA is valid.
- PIX_READY output 1: driver accepts a pixel this cycle.
- PIX_INDEX output clog2(LEDS) (min 1): index of the next pixel to be accepted.
- WS output CHANNELS: serial data line per string, registered.
- BUSY output 1: high in any state except IDLE.
- FRAME_DONE output 1: one-cycle pulse at the end of the latch period.
- UNDERRUN output 1: sticky; cleared when a frame starts.
- STATE output 2: state code: IDLE=0, FETCH=1, SHIFT=2, LATCH=3.

Behaviour:
- Reset (asynchronous, RESET_N=0), immediate even mid-frame:
  - STATE=IDLE, WS=0, PIX_READY=0, PIX_INDEX=0, BUSY=0, FRAME_DONE=0, UNDERRUN=0.
  - Shift register, holding buffer, counters and flags cleared.
- Handshake:
  - A transfer occurs when PIX_VALID & PIX_READY are both high on a clock edge.
  - PIX_READY = (FETCH, or SHIFT with holding buffer empty) & (pixels accepted this frame < LEDS).
  - PIX_INDEX increments on each transfer and resets to 0 at each frame start.
- IDLE:
  - WS=0.
  - START, or CONTINUOUS while entering from LATCH, moves to FETCH, clears UNDERRUN and zeroes PIX_INDEX.
- FETCH: on transfer, load the shift register, set bit index = BPP-1 and cnt=0, go to SHIFT.
- SHIFT:
  - cnt runs 0..TBIT-1.
  - WS[c] is registered; WS[c]=1 while cnt < (current bit of channel c ? T1H : T0H), else 0.
  - First WS rise occurs one cycle after the loading transfer.
  - At cnt=TBIT-1 with bit index > 0: bit index decrements and cnt=0.
  - At cnt=TBIT-1 with bit index = 0:
    - Last pixel of the frame: go to LATCH.
    - Holding buffer full: move the holding buffer into the shift register, empty the buffer, continue with no gap.
    - Holding buffer empty (underrun): set UNDERRUN=1 and go to LATCH, truncating the frame.
- A transfer coinciding with the buffer moving into the shift register is impossible, because READY=0 while the buffer is full.
- LATCH:
  - WS=0 for TRST clocks.
  - On the last latch clock, FRAME_DONE=1 for exactly one cycle.
  - Next state is FETCH if CONTINUOUS=1, else IDLE.
- START outside IDLE is ignored. CONTINUOUS is sampled only at the end of LATCH.
- Nominal frame length: LEDS*BPP*TBIT + TRST clocks from the first WS rise to FRAME_DONE, provided the source never starves.

Test Plan:
- Reset and idle (CHANNELS=2, LEDS=3, BPP=24, defaults): release RESET_N -> WS=00, BUSY=0; pulse START, PIX_VALID held 1 -> first WS rise 2 cycles after START.
- Bit patterns: ch0=0xFF0000, ch1=0x00FF00 on all pixels -> ch0 high 40 clocks and ch1 high 20 clocks for the first 8 bits; both then low 23 and 43 clocks respectively; every bit period is exactly 63 clocks.
- Full frame: always-valid source -> 3 transfers, PIX_INDEX 0,1,2; FRAME_DONE exactly 3*24*63+2500 = 7036 clocks after the first rise; STATE returns to 0.
- Underrun: withhold the pixel for index 1 -> after 24 bits WS=00 and LATCH entered; UNDERRUN=1; FRAME_DONE after 2500 clocks; the next START clears UNDERRUN.
- Continuous mode: CONTINUOUS=1 -> after FRAME_DONE, STATE=1 on the next cycle and PIX_INDEX=0; START pulses during SHIFT have no effect.
- Async reset mid-SHIFT while WS high -> WS=00 with no clock edge; STATE=0; no FRAME_DONE.
